// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, result-stage FSM states and op classification helpers
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NEG  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_SHL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } op_e;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  function automatic logic is_comb_op(input logic [3:0] op);
    return op <= OP_ROL;
  endfunction

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: selects the combinational unit result for an op and flags illegal codes
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] arith_result,
  input  logic [DATA_W-1:0] shl_result,
  input  logic [DATA_W-1:0] shr_result,
  input  logic [DATA_W-1:0] shra_result,
  input  logic [DATA_W-1:0] ror_result,
  input  logic [DATA_W-1:0] rol_result,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);
  // add/sub/and/or/neg/not arrive pre-muxed, so they share one input
  always_comb begin
    result  = op <= OP_NOT  ? arith_result :
              op == OP_SHR  ? shr_result   :
              op == OP_SHRA ? shra_result  :
              op == OP_SHL  ? shl_result   :
              op == OP_ROR  ? ror_result   :
              op == OP_ROL  ? rol_result   : '0;
    illegal = op > OP_DIV;
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures the selected ALU or mul/div result into the Z register pair
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int OP_W           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   arith_result,
  input  logic [DATA_W-1:0]   shl_result,
  input  logic [DATA_W-1:0]   shr_result,
  input  logic [DATA_W-1:0]   shra_result,
  input  logic [DATA_W-1:0]   ror_result,
  input  logic [DATA_W-1:0]   rol_result,
  input  logic [2*DATA_W-1:0] mul_result,
  input  logic [DATA_W-1:0]   div_quot,
  input  logic [DATA_W-1:0]   div_rem,
  input  logic                muldiv_valid,
  output logic                muldiv_start,
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                flag_zero,
  output logic                flag_neg
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d, sel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, fz_q, fz_d, fn_q, fn_d, mds_q, mds_d, is_mul_q, is_mul_d, illegal;
  logic [3:0]        opc;

  assign opc = 4'(op);

  alu_result_mux #(.DATA_W(DATA_W)) u_mux (
    .op           (opc),
    .arith_result (arith_result),
    .shl_result   (shl_result),
    .shr_result   (shr_result),
    .shra_result  (shra_result),
    .ror_result   (ror_result),
    .rol_result   (rol_result),
    .result       (sel),
    .illegal      (illegal)
  );

  // next-state: accept starts only in IDLE, wait on mul/div with a timeout, pulse done once
  always_comb begin
    state_d  = state_q;
    z_hi_d   = z_hi_q;
    z_lo_d   = z_lo_q;
    err_d    = err_q;
    fz_d     = fz_q;
    fn_d     = fn_q;
    mds_d    = 1'b0;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    case (state_q)
      IDLE: if (start) begin
        err_d   = illegal;
        state_d = is_muldiv_op(opc) ? WAIT : DONE;
        if (is_comb_op(opc)) begin
          z_lo_d = sel;
          z_hi_d = '0;
          fz_d   = sel == '0;
          fn_d   = sel[DATA_W-1];
        end
        if (is_muldiv_op(opc)) begin
          mds_d    = 1'b1;
          cnt_d    = '0;
          is_mul_d = opc == OP_MUL;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (muldiv_valid) begin
          state_d = DONE;
          {z_hi_d, z_lo_d} = is_mul_q ? mul_result : {div_rem, div_quot};
          fz_d = is_mul_q ? mul_result == '0 : div_quot == '0;
          fn_d = is_mul_q ? mul_result[2*DATA_W-1] : div_quot[DATA_W-1];
        end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; clr overrides everything
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      z_hi_q   <= '0;
      z_lo_q   <= '0;
      err_q    <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      mds_q    <= 1'b0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      z_hi_q   <= z_hi_d;
      z_lo_q   <= z_lo_d;
      err_q    <= err_d;
      fz_q     <= fz_d;
      fn_q     <= fn_d;
      mds_q    <= mds_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
    end
  end

  assign muldiv_start = mds_q;
  assign z_hi         = z_hi_q;
  assign z_lo         = z_lo_q;
  assign busy         = state_q == WAIT;
  assign done         = state_q == DONE;
  assign err          = err_q;
  assign flag_zero    = fz_q;
  assign flag_neg     = fn_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized self-checking bench against a transaction-level model
module tb_alu_result_stage;
  localparam int TO = 64;

  logic        clk = 1'b0, clr = 1'b0, start = 1'b0, muldiv_valid = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] arith_result = '0, shl_result = '0, shr_result = '0, shra_result = '0;
  logic [31:0] ror_result = '0, rol_result = '0, div_quot = '0, div_rem = '0;
  logic [63:0] mul_result = '0;
  logic        muldiv_start, busy, done, err, flag_zero, flag_neg;
  logic [31:0] z_hi, z_lo;

  int checks = 0, errors = 0;
  logic [31:0] m_hi, m_lo;
  logic        m_zero, m_neg, m_err;

  alu_result_stage #(.DATA_W(32), .OP_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .arith_result(arith_result), .shl_result(shl_result), .shr_result(shr_result),
    .shra_result(shra_result), .ror_result(ror_result), .rol_result(rol_result),
    .mul_result(mul_result), .div_quot(div_quot), .div_rem(div_rem),
    .muldiv_valid(muldiv_valid), .muldiv_start(muldiv_start),
    .z_hi(z_hi), .z_lo(z_lo), .busy(busy), .done(done), .err(err),
    .flag_zero(flag_zero), .flag_neg(flag_neg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o);
    start = 1'b1;
    op = o;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_inputs;
    arith_result = $urandom;
    shl_result   = $urandom;
    shr_result   = $urandom;
    shra_result  = $urandom;
    ror_result   = $urandom;
    rol_result   = $urandom;
  endtask

  function automatic logic [31:0] ref_sel(input int o);
    case (o)
      0, 1, 2, 3, 4, 5: return arith_result;
      6: return shr_result;
      7: return shra_result;
      8: return shl_result;
      9: return ror_result;
      default: return rol_result;
    endcase
  endfunction

  task automatic test_reset;
    clr = 1'b1;
    start = 1'b1;
    op = 4'd8;
    tick();
    tick();
    start = 1'b0;
    clr = 1'b0;
    {m_hi, m_lo, m_zero, m_neg, m_err} = '0;
    checks++;
    if ({z_hi, z_lo, busy, done, err, flag_zero, flag_neg, muldiv_start} !== 70'd0) begin
      errors++;
      $display("FAIL reset: z=%h_%h b=%b d=%b e=%b fz=%b fn=%b ms=%b, required all zero",
               z_hi, z_lo, busy, done, err, flag_zero, flag_neg, muldiv_start);
    end
  endtask

  task automatic test_comb(input int o, input bit rnd);
    logic [31:0] s;
    if (rnd) rand_inputs();
    s = ref_sel(o);
    issue(4'(o));
    m_hi = '0;
    m_lo = s;
    m_zero = s == 0;
    m_neg = s[31];
    m_err = 1'b0;
    checks++;
    if ({done, busy, z_hi, z_lo, flag_zero, flag_neg, err} !== {2'b10, m_hi, m_lo, m_zero, m_neg, m_err}) begin
      errors++;
      $display("FAIL comb_op%0d: d=%b b=%b z=%h_%h fz=%b fn=%b e=%b, required d=1 b=0 z=%h_%h fz=%b fn=%b e=%b",
               o, done, busy, z_hi, z_lo, flag_zero, flag_neg, err, m_hi, m_lo, m_zero, m_neg, m_err);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL comb_done_width op%0d: done=%b required 0", o, done);
    end
  endtask

  task automatic test_illegal(input logic [3:0] o);
    rand_inputs();
    issue(o);
    m_err = 1'b1;
    checks++;
    if ({done, z_hi, z_lo, flag_zero, flag_neg, err} !== {1'b1, m_hi, m_lo, m_zero, m_neg, m_err}) begin
      errors++;
      $display("FAIL illegal_op%0d: d=%b z=%h_%h fz=%b fn=%b e=%b, required d=1 z=%h_%h fz=%b fn=%b e=1",
               o, done, z_hi, z_lo, flag_zero, flag_neg, err, m_hi, m_lo, m_zero, m_neg);
    end
    tick();
  endtask

  // lat < 0 means the unit never answers, so the timeout must fire
  task automatic test_muldiv(input logic [3:0] o, input int lat, input logic [63:0] prod,
                             input logic [31:0] q, input logic [31:0] r);
    int n;
    n = lat < 0 ? TO - 1 : lat;
    issue(o);
    checks++;
    if ({muldiv_start, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL muldiv_launch: ms=%b b=%b d=%b, required 1 1 0", muldiv_start, busy, done);
    end
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if ({muldiv_start, busy, done} !== 3'b010) begin
        errors++;
        $display("FAIL muldiv_wait cycle %0d: ms=%b b=%b d=%b, required 0 1 0", k + 1, muldiv_start, busy, done);
      end
    end
    if (lat >= 0) begin
      muldiv_valid = 1'b1;
      mul_result = prod;
      div_quot = q;
      div_rem = r;
    end
    tick();
    muldiv_valid = 1'b0;
    if (lat < 0) m_err = 1'b1;
    else if (o == 4'd11) begin
      {m_hi, m_lo} = prod;
      m_zero = prod == 0;
      m_neg = prod[63];
      m_err = 1'b0;
    end else begin
      m_hi = r;
      m_lo = q;
      m_zero = q == 0;
      m_neg = q[31];
      m_err = 1'b0;
    end
    checks++;
    if ({done, busy, z_hi, z_lo, flag_zero, flag_neg, err} !== {2'b10, m_hi, m_lo, m_zero, m_neg, m_err}) begin
      errors++;
      $display("FAIL muldiv_op%0d_lat%0d: d=%b b=%b z=%h_%h fz=%b fn=%b e=%b, required d=1 b=0 z=%h_%h fz=%b fn=%b e=%b",
               o, lat, done, busy, z_hi, z_lo, flag_zero, flag_neg, err, m_hi, m_lo, m_zero, m_neg, m_err);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL muldiv_done_width: done=%b required 0", done);
    end
  endtask

  task automatic test_shift;
    arith_result = $urandom;
    shl_result   = 32'h0000_0030;
    shr_result   = 32'h0800_0000;
    shra_result  = 32'hF800_0000;
    test_comb(8, 1'b0);
    test_comb(7, 1'b0);
  endtask

  task automatic test_mul;
    test_muldiv(4'd11, 5, 64'hFFFF_FFFF_FFFF_FFFE, $urandom, $urandom);
  endtask

  task automatic test_div_timeout;
    shl_result = 32'h0000_0030;
    test_comb(8, 1'b0);
    test_muldiv(4'd12, -1, '0, '0, '0);
  endtask

  task automatic test_illegal_then_zero;
    test_illegal(4'd14);
    shr_result = 32'h0;
    test_comb(6, 1'b0);
  endtask

  task automatic test_clr_mid_wait;
    bit seen;
    issue(4'd11);
    tick();
    start = 1'b1;
    op = 4'd8;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL start_while_busy: b=%b d=%b, required 1 0", busy, done);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    {m_hi, m_lo, m_zero, m_neg, m_err} = '0;
    muldiv_valid = 1'b1;
    mul_result = 64'h1234_5678_9ABC_DEF0;
    tick();
    muldiv_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || {z_hi, z_lo, err, flag_zero, flag_neg} !== 67'd0) begin
      errors++;
      $display("FAIL clr_mid_wait: stray d/b=%b z=%h_%h e=%b fz=%b fn=%b, required no pulse and all zero",
               seen, z_hi, z_lo, err, flag_zero, flag_neg);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      issue(4'($urandom_range(0, 10)));
      m_hi = '0;
      m_lo = ref_sel(int'(op));
      m_zero = m_lo == 0;
      m_neg = m_lo[31];
      m_err = 1'b0;
      rand_inputs();
      start = 1'b1;
      op = 4'($urandom_range(0, 10));
      tick();
      start = 1'b0;
      checks++;
      if ({done, z_hi, z_lo, flag_zero, flag_neg} !== {1'b0, m_hi, m_lo, m_zero, m_neg}) begin
        errors++;
        $display("FAIL start_in_done: d=%b z=%h_%h fz=%b fn=%b, required d=0 z=%h_%h fz=%b fn=%b",
                 done, z_hi, z_lo, flag_zero, flag_neg, m_hi, m_lo, m_zero, m_neg);
      end
      test_comb(int'($urandom_range(0, 10)), 1'b1);
    end
  endtask

  task automatic test_random;
    logic [63:0] p;
    logic [31:0] q;
    int lat;
    for (int i = 0; i < 30; i++) test_comb(int'($urandom_range(0, 10)), 1'b1);
    for (int i = 0; i < 3; i++) test_illegal(4'($urandom_range(13, 15)));
    for (int i = 0; i < 10; i++) begin
      p = {$urandom, $urandom};
      q = $urandom;
      if (i % 4 == 1) begin
        p = '0;
        q = '0;
      end
      lat = i == 3 ? TO - 1 : i == 7 ? -1 : int'($urandom_range(0, 10));
      test_muldiv(i % 2 == 0 ? 4'd11 : 4'd12, lat, p, q, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_mul();
    test_div_timeout();
    test_illegal_then_zero();
    test_clr_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream consumer of the combinational ALU units (alu_shl, alu_shr, alu_shra, rotate, arithmetic/logic) and of the sequential multiply/divide units.
- On a start pulse it selects the result for the requested op and captures it into the 64-bit Z register pair (ZHi/ZLo) that later drives the bus.
- For MUL/DIV it launches the unit, waits for its valid with a timeout, then captures, and reports done/err/flags.

Parameters:
- DATA_W, 32, width of one Z half and of each combinational result.
- OP_W, 4, width of the op code.
- TIMEOUT_CYCLES, 64, maximum cycles WAIT may last before err is raised; must be ≥2.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  OP_W  operation code (package encoding).
- arith_result  in  DATA_W  pre-muxed add/sub/and/or/neg/not result.
- shl_result  in  DATA_W  alu_shl output.
- shr_result  in  DATA_W  alu_shr output.
- shra_result  in  DATA_W  alu_shra output.
- ror_result  in  DATA_W  rotate-right output.
- rol_result  in  DATA_W  rotate-left output.
- mul_result  in  2*DATA_W  multiplier product {hi,lo}.
- div_quot  in  DATA_W  divider quotient.
- div_rem  in  DATA_W  divider remainder.
- muldiv_valid  in  1  one-cycle result-ready from mul/div.
- muldiv_start  out  1  one-cycle launch pulse to mul/div.
- z_hi  out  DATA_W  ZHi register.
- z_lo  out  DATA_W  ZLo register.
- busy  out  1  high in WAIT.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky until next accepted start or clr; set on timeout or illegal op.
- flag_zero  out  1  registered; Z value captured equals zero.
- flag_neg  out  1  registered; sign bit of captured value.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous and active-high.
- Reset: all outputs 0; FSM to IDLE; timeout counter 0. clr wins over every other event, including mid-WAIT. A muldiv_valid arriving after clr is ignored.
- IDLE: start with a combinational op (ADD..ROL) captures on the same edge:
  - z_lo <= selected result; z_hi <= 0.
  - Flags: zero = (selected == 0); neg = selected[31].
  - Next state DONE, so done is high in the cycle after start (latency 1).
- IDLE, start with MUL or DIV:
  - muldiv_start = 1 for exactly the next cycle.
  - Counter cleared; go to WAIT.
  - err is cleared on any accepted start.
- IDLE, start with an illegal op: Z and flags unchanged; err = 1; go to DONE.
- WAIT: busy = 1; counter increments every cycle.
  - muldiv_valid, MUL: {z_hi, z_lo} <= mul_result; flags computed over 64 bits, with neg = bit 63.
  - muldiv_valid, DIV: z_lo <= div_quot, z_hi <= div_rem; flags from the quotient only.
  - After either capture, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no valid: Z unchanged, err = 1, go to DONE.
  - If valid and timeout coincide, valid wins.
- DONE: done = 1 for one cycle, then IDLE. A start during DONE or WAIT is ignored and is not queued.
- Z holds its value indefinitely between operations.

Decomposition:
- Package alu_pkg holds:
  - op encoding: ADD=0, SUB=1, AND=2, OR=3, NEG=4, NOT=5, SHR=6, SHRA=7, SHL=8, ROR=9, ROL=10, MUL=11, DIV=12; 13-15 illegal.
  - FSM state typedef {IDLE, WAIT, DONE}.
  - is_comb_op / is_muldiv_op helper functions.
- One natural sub-module, alu_result_mux: the purely combinational selector from op to 32-bit result, plus the illegal-op flag.

Test Plan:
- Shift inputs derived from 0x80000003 shifted by 4: shl_result = 0x00000030, shr_result = 0x08000000, shra_result = 0xF8000000.
  - start with SHL -> next cycle done = 1, z_lo = 0x00000030, z_hi = 0, flag_neg = 0.
  - start with SHRA -> z_lo = 0xF8000000, flag_neg = 1.
- MUL: start; muldiv_valid asserted 5 cycles after muldiv_start with mul_result = 0xFFFFFFFF_FFFFFFFE.
  - muldiv_start is exactly one cycle; busy is high throughout WAIT.
  - z_hi = 0xFFFFFFFF, z_lo = 0xFFFFFFFE, flag_neg = 1, then done for one cycle.
- DIV with no valid: err = 1 and done at TIMEOUT_CYCLES cycles after entering WAIT; Z keeps the prior value 0x00000030.
- Illegal op 14 -> done next cycle, err = 1, Z unchanged. A following SHR start with shr_result = 0 clears err and sets flag_zero = 1.
- clr asserted mid-WAIT, then muldiv_valid -> state IDLE, Z = 0, done never pulses. A start issued while busy is ignored.
